// File: rtl/baud_gen_frac.sv
// Fractional-N baud generator: oversample ticks every act_int(+carry) clocks,
// with bit-period and bit-centre strobes derived from the oversample phase.
module baud_gen_frac #(
   parameter int unsigned clk_freq   = 50000000,
   parameter int unsigned baud_rate  = 9600,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned DIV_W      = 16,
   parameter int unsigned FRAC_W     = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic                          div_load,
   input  logic [DIV_W-1:0]              div_int,
   input  logic [FRAC_W-1:0]             div_frac,
   output logic                          os_tick,
   output logic                          baud_tick,
   output logic                          mid_tick,
   output logic [$clog2(OVERSAMPLE)-1:0] os_phase
);

   localparam int unsigned PH_W = $clog2(OVERSAMPLE);

   // Reset divisor computed at elaboration in 64 bits to avoid overflow.
   localparam logic [63:0] DEN        = 64'(baud_rate) * 64'(OVERSAMPLE);
   localparam logic [63:0] DEF_INT_W  = 64'(clk_freq) / DEN;
   localparam logic [63:0] DEF_FRAC_W = (64'(clk_freq) << FRAC_W) / DEN;
   localparam logic [DIV_W-1:0]  DEF_INT  = DEF_INT_W[DIV_W-1:0];
   localparam logic [FRAC_W-1:0] DEF_FRAC = DEF_FRAC_W[FRAC_W-1:0];

   localparam logic [PH_W-1:0] LAST_PH = PH_W'(OVERSAMPLE - 1);
   localparam logic [PH_W-1:0] MID_PH  = PH_W'(OVERSAMPLE / 2 - 1);

   logic [DIV_W-1:0]  act_int;
   logic [DIV_W-1:0]  eff_int;
   logic [FRAC_W-1:0] act_frac;
   logic [FRAC_W-1:0] acc;
   logic [FRAC_W:0]   acc_sum;
   logic [DIV_W:0]    cnt;
   logic [DIV_W:0]    last;
   logic              c;
   logic              hit;

   always_comb begin
      eff_int = (act_int < DIV_W'(2)) ? DIV_W'(2) : act_int;
      last    = {1'b0, eff_int} + {{DIV_W{1'b0}}, c} - (DIV_W+1)'(1);
      hit     = (cnt == last);
      acc_sum = {1'b0, acc} + {1'b0, act_frac};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_int   <= DEF_INT;
         act_frac  <= DEF_FRAC;
         cnt       <= '0;
         acc       <= '0;
         c         <= 1'b0;
         os_phase  <= '0;
         os_tick   <= 1'b0;
         baud_tick <= 1'b0;
         mid_tick  <= 1'b0;
      end else if (div_load) begin
         // A load wins over any tick due this cycle; the period restarts from zero.
         act_int   <= div_int;
         act_frac  <= div_frac;
         cnt       <= '0;
         acc       <= '0;
         c         <= 1'b0;
         os_phase  <= '0;
         os_tick   <= 1'b0;
         baud_tick <= 1'b0;
         mid_tick  <= 1'b0;
      end else if (!enable) begin
         cnt       <= '0;
         acc       <= '0;
         c         <= 1'b0;
         os_phase  <= '0;
         os_tick   <= 1'b0;
         baud_tick <= 1'b0;
         mid_tick  <= 1'b0;
      end else begin
         os_tick   <= hit;
         baud_tick <= hit && (os_phase == LAST_PH);
         mid_tick  <= hit && (os_phase == MID_PH);
         if (hit) begin
            cnt      <= '0;
            acc      <= acc_sum[FRAC_W-1:0];
            c        <= acc_sum[FRAC_W];
            os_phase <= os_phase + PH_W'(1);
         end else begin
            cnt <= cnt + (DIV_W+1)'(1);
         end
      end
   end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac: default divisor cadence, fractional loads,
// clamp, enable drop, load-vs-tick priority and asynchronous reset.
module tb_baud_gen_frac;
   localparam int DIV_W  = 16;
   localparam int FRAC_W = 4;
   localparam int PH_W   = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              enable = 1'b0;
   logic              div_load = 1'b0;
   logic [DIV_W-1:0]  div_int = '0;
   logic [FRAC_W-1:0] div_frac = '0;
   logic              os_tick;
   logic              baud_tick;
   logic              mid_tick;
   logic [PH_W-1:0]   os_phase;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   baud_gen_frac dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .div_load  (div_load),
      .div_int   (div_int),
      .div_frac  (div_frac),
      .os_tick   (os_tick),
      .baud_tick (baud_tick),
      .mid_tick  (mid_tick),
      .os_phase  (os_phase)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Counts edges until os_tick is seen; -1 if the bound expires.
   task automatic wait_tick(input int limit, output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!os_tick && n < limit);
      if (!os_tick) n = -1;
   endtask

   task automatic load(input int di, input int df);
      div_int  = DIV_W'(di);
      div_frac = FRAC_W'(df);
      div_load = 1'b1;
      cycles(1);
      div_load = 1'b0;
   endtask

   initial begin
      int n;
      int sum;
      int exp_n;

      // Reset state
      #12;
      check("rst_os_tick", 32'(os_tick), 0);
      check("rst_baud_tick", 32'(baud_tick), 0);
      check("rst_mid_tick", 32'(mid_tick), 0);
      check("rst_os_phase", 32'(os_phase), 0);
      check("rst_act_int", 32'(dut.act_int), 325);
      check("rst_act_frac", 32'(dut.act_frac), 8);
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      enable = 1'b1;

      // Default divisor 325 + 8/16
      sum = 0;
      for (int i = 1; i <= 32; i++) begin
         wait_tick(400, n);
         exp_n = (i == 1) ? 325 : ((i % 2 == 0) ? 325 : 326);
         check($sformatf("def_interval_%0d", i), 32'(n), 32'(exp_n));
         check($sformatf("def_baud_%0d", i), 32'(baud_tick), 32'(i % 16 == 0));
         check($sformatf("def_mid_%0d", i), 32'(mid_tick), 32'(i % 16 == 8));
         sum += n;
         if (i == 16) begin
            check("def_first_bit_clocks", 32'(sum), 5207);
            sum = 0;
         end
      end
      check("def_second_bit_clocks", 32'(sum), 5208);

      // Load 4 + 4/16 while running
      load(4, 4);
      check("load_os_tick", 32'(os_tick), 0);
      check("load_os_phase", 32'(os_phase), 0);
      for (int i = 1; i <= 16; i++) begin
         wait_tick(20, n);
         exp_n = (i > 1 && (i - 1) % 4 == 0) ? 5 : 4;
         check($sformatf("frac_interval_%0d", i), 32'(n), 32'(exp_n));
         check($sformatf("frac_mid_%0d", i), 32'(mid_tick), 32'(i == 8));
         check($sformatf("frac_baud_%0d", i), 32'(baud_tick), 32'(i == 16));
         check($sformatf("frac_phase_%0d", i), 32'(os_phase), 32'(i % 16));
      end

      // Next period is 5 (carry set); load lands on the edge that would tick
      cycles(4);
      load(6, 0);
      check("prio_os_tick", 32'(os_tick), 0);
      check("prio_os_phase", 32'(os_phase), 0);
      wait_tick(20, n);
      check("prio_new_period", 32'(n), 6);

      // Clamp: div_int=1 behaves as 2
      load(1, 0);
      for (int i = 1; i <= 3; i++) begin
         wait_tick(10, n);
         check($sformatf("clamp_interval_%0d", i), 32'(n), 2);
      end

      // Enable drop mid-period
      load(6, 0);
      for (int i = 1; i <= 3; i++) begin
         wait_tick(20, n);
         check($sformatf("en_interval_%0d", i), 32'(n), 6);
      end
      check("en_phase_before", 32'(os_phase), 3);
      cycles(2);
      check("en_cnt_before", 32'(dut.cnt), 2);
      enable = 1'b0;
      cycles(1);
      check("dis_os_tick", 32'(os_tick), 0);
      check("dis_os_phase", 32'(os_phase), 0);
      check("dis_cnt", 32'(dut.cnt), 0);
      sum = 0;
      for (int i = 0; i < 10; i++) begin
         cycles(1);
         sum += int'(os_tick);
      end
      check("dis_no_ticks", 32'(sum), 0);
      enable = 1'b1;
      wait_tick(20, n);
      check("reen_first_interval", 32'(n), 6);
      check("reen_phase", 32'(os_phase), 1);

      // Async reset with os_phase = 9
      for (int i = 0; i < 8; i++) wait_tick(20, n);
      check("pre_rst_phase", 32'(os_phase), 9);
      check("pre_rst_os_tick", 32'(os_tick), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_os_tick", 32'(os_tick), 0);
      check("arst_os_phase", 32'(os_phase), 0);
      check("arst_act_int", 32'(dut.act_int), 325);
      check("arst_act_frac", 32'(dut.act_frac), 8);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      wait_tick(400, n);
      check("post_rst_interval", 32'(n), 325);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/baud_gen_frac.md
BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

Interface
REQ-001 Parameter clk_freq, default 50000000: input clock frequency in Hz.
REQ-002 Parameter baud_rate, default 9600: baud rate loaded at reset.
REQ-003 Parameter OVERSAMPLE, default 16: os_tick pulses per bit period; power of two, at least 4.
REQ-004 Parameter DIV_W, default 16: width of the integer divisor.
REQ-005 Parameter FRAC_W, default 4: width of the fractional divisor.
REQ-006 clk  input  1: single clock; all logic on its rising edge.
REQ-007 rst_n  input  1: asynchronous, active-low reset.
REQ-008 enable  input  1: run the generator; low clears the counters.
REQ-009 div_load  input  1: one-cycle strobe that captures div_int and div_frac.
REQ-010 div_int  input  DIV_W: integer clocks per os_tick.
REQ-011 div_frac  input  FRAC_W: fractional clocks per os_tick, in units of 1/2^FRAC_W.
REQ-012 os_tick  output  1: registered one-cycle oversample pulse.
REQ-013 baud_tick  output  1: registered one-cycle pulse, once per bit period.
REQ-014 mid_tick  output  1: registered one-cycle pulse at the bit-centre sample point.
REQ-015 os_phase  output  $clog2(OVERSAMPLE): current oversample index, 0..OVERSAMPLE-1.

Function
REQ-016 The block SHALL hold active registers act_int and act_frac; reset values are DEF_INT = clk_freq/(baud_rate*OVERSAMPLE) and DEF_FRAC = (clk_freq*2^FRAC_W/(baud_rate*OVERSAMPLE)) mod 2^FRAC_W, both integer-truncated (defaults give 325 and 8).
REQ-017 Values of act_int below 2 SHALL be treated as 2.
REQ-018 The period of each os_tick SHALL be P = act_int + c clocks, where c is the carry from the previous accumulator update; c is 0 for the first period after a clear.
REQ-019 The clock counter cnt SHALL increment each enabled cycle; when cnt == P-1: cnt <= 0, os_tick <= 1, acc <= (acc + act_frac) mod 2^FRAC_W, c <= carry-out of that sum.
REQ-020 os_tick SHALL be low in every cycle in which it is not generated by REQ-019.
REQ-021 os_phase SHALL advance by 1 on each os_tick and wrap from OVERSAMPLE-1 to 0.
REQ-022 baud_tick SHALL assert in the same cycle as an os_tick whose pre-increment os_phase was OVERSAMPLE-1.
REQ-023 mid_tick SHALL assert in the same cycle as an os_tick whose pre-increment os_phase was OVERSAMPLE/2-1.
REQ-024 When enable is low, cnt, acc, c and os_phase SHALL be 0 and all tick outputs low.
REQ-025 The first os_tick SHALL appear act_int enabled cycles after enable rises, with no glitch or partial period.
REQ-026 On div_load high, act_int and act_frac SHALL be loaded, and cnt, acc, c and os_phase cleared, that same edge; all ticks low that cycle; this applies regardless of enable.
REQ-027 div_load SHALL take priority over a coincident tick; the tick is suppressed, not deferred.
REQ-028 All counters SHALL wrap within their declared widths; cnt SHALL be DIV_W+1 bits so that P = 2^DIV_W-1+1 is representable.
REQ-029 Outputs SHALL be driven only from registers, with no combinational path from inputs.

Reset
REQ-030 While rst_n is low: os_tick = baud_tick = mid_tick = 0, os_phase = 0, cnt = acc = c = 0, act_int = DEF_INT, act_frac = DEF_FRAC.
REQ-031 Reset assertion mid-period SHALL abort the period immediately.
REQ-032 After reset deassertion, timing SHALL restart per REQ-025.

Verification
REQ-033 Defaults, enable held high: os_tick intervals alternate 325,325,326,325,326...; baud_tick every 16th os_tick, averaging 5208 clocks.
REQ-034 div_load with div_int=4, div_frac=4, enable high: os_tick intervals 4,4,4,4,5,4,4,4,5 -> mid_tick on os_tick #8, baud_tick on os_tick #16, os_phase back to 0.
REQ-035 div_int=1, div_frac=0: os_tick every 2 clocks (clamp per REQ-017).
REQ-036 enable dropped when cnt=2: next cycle all ticks 0, os_phase 0; re-enable -> first os_tick after act_int cycles.
REQ-037 div_load asserted in the cycle a tick would fire: no tick; new period counted from 0.
REQ-038 rst_n pulsed low mid-bit with os_phase=9: outputs 0 and os_phase 0 asynchronously; act_int returns to 325.
